// File: rtl/alu_flag_commit_pkg.sv
// -----------------------------------------------------------------------------
// alu_flag_commit_pkg
// Shared definitions for the EX->WB flag commit stage:
//   - datapath / flag-vector / CR geometry
//   - XER bit indices and ALU flag-vector (D) bit positions
//   - wb_slot_t: everything the WB slot carries for one instruction
// All vectors are big-endian: bit 0 is the most significant bit.
// -----------------------------------------------------------------------------
package alu_flag_commit_pkg;

  // Geometry
  localparam int ARCH_W = 32;  // datapath width
  localparam int D_W    = 8;   // ALU flag vector width
  localparam int CRF_N  = 8;   // number of CR fields
  localparam int CRF_W  = 4;   // bits per CR field {LT,GT,EQ,SO}
  localparam int RD_W   = 5;   // GPR index width
  localparam int CRFD_W = 3;   // CR field index width

  // XER bit indices
  localparam int XER_SO = 0;
  localparam int XER_OV = 1;
  localparam int XER_CA = 2;

  // ALU flag vector D = {CA, OV, LT0, GT0, EQ0, LTx, GTx, EQx}
  localparam int D_CA  = 0;
  localparam int D_OV  = 1;
  localparam int D_CR0 = 2;  // first of three CR0 condition bits
  localparam int D_CRX = 5;  // first of three compare condition bits
  localparam int CR3_W = 3;  // LT/GT/EQ part of a CR field

  // One instruction held in the WB slot
  typedef struct packed {
    logic              valid;
    logic [0:ARCH_W-1] c;
    logic [0:D_W-1]    d;
    logic [0:RD_W-1]   rd;
    logic              gpr_we;
    logic              ca_we;
    logic              ov_we;
    logic              cr0_we;
    logic              crx_we;
    logic [0:CRFD_W-1] crfd;
    logic              mtxer;
    logic              mtcrf;
    logic [0:CRF_N-1]  crm;
  } wb_slot_t;

  // True when a valid slot will change XER or CR on its commit edge.
  function automatic logic slot_writes_flags(wb_slot_t s);
    return s.valid & (s.ca_we | s.ov_we | s.cr0_we | s.crx_we | s.mtxer | s.mtcrf);
  endfunction

endpackage

// File: rtl/alu_flag_commit_flag_merge.sv
// -----------------------------------------------------------------------------
// alu_flag_commit_flag_merge
// Combinational merge of one WB slot into the architectural XER and CR.
// This is the single definition of merge priority, shared by the commit
// path and the ALU bypass path.
//
// Ports (big-endian vectors):
//   valid             in  slot holds a real instruction (else pass-through)
//   d[0:7]            in  ALU flag vector {CA,OV,CR0_3,CRX_3}
//   ca_we/ov_we       in  XER[CA] / XER[OV]+sticky SO update
//   cr0_we/crx_we     in  CR field 0 / CR field crfd update
//   crfd[0:2]         in  compare target field
//   mtxer/mtcrf       in  move-to XER / move-to CR fields selected by crm
//   crm[0:7]          in  mtcrf field mask, bit i selects field i
//   c[0:31]           in  mtxer/mtcrf source data
//   xer/cr[0:31]      in  current architectural values
//   xer_next/cr_next  out values after this slot commits
//
// Priority, lowest to highest:
//   XER: ca/ov flag writes, then mtxer replaces the whole register.
//   CR : cr0 write, then crx write (wins on field 0), then mtcrf on
//        masked fields.
//   The SO bit written into CR fields is the final post-commit XER[SO].
// -----------------------------------------------------------------------------
module alu_flag_commit_flag_merge
  import alu_flag_commit_pkg::*;
(
  input  logic              valid,
  input  logic [0:D_W-1]    d,
  input  logic              ca_we,
  input  logic              ov_we,
  input  logic              cr0_we,
  input  logic              crx_we,
  input  logic [0:CRFD_W-1] crfd,
  input  logic              mtxer,
  input  logic              mtcrf,
  input  logic [0:CRF_N-1]  crm,
  input  logic [0:ARCH_W-1] c,
  input  logic [0:ARCH_W-1] xer,
  input  logic [0:ARCH_W-1] cr,
  output logic [0:ARCH_W-1] xer_next,
  output logic [0:ARCH_W-1] cr_next
);

  logic so_new;

  always_comb begin
    // NOTE: every output gets a default before any conditional update, so no
    // path through the block leaves a value unassigned (no latch).
    xer_next = xer;
    cr_next  = cr;
    so_new   = xer[XER_SO];

    if (valid) begin
      // XER flag updates; SO is sticky and only set here.
      if (ca_we) begin
        xer_next[XER_CA] = d[D_CA];
      end
      if (ov_we) begin
        xer_next[XER_OV] = d[D_OV];
        xer_next[XER_SO] = xer[XER_SO] | d[D_OV];
      end
      // mtxer replaces the register outright, including clearing SO.
      if (mtxer) begin
        xer_next = c;
      end
      so_new = xer_next[XER_SO];

      if (cr0_we) begin
        cr_next[0 +: CRF_W] = {d[D_CR0 +: CR3_W], so_new};
      end
      // Applied after cr0 so a compare into field 0 wins.
      if (crx_we) begin
        cr_next[CRF_W*int'(crfd) +: CRF_W] = {d[D_CRX +: CR3_W], so_new};
      end
      // mtcrf has the last word on every field it selects.
      if (mtcrf) begin
        for (int n = 0; n < CRF_N; n++) begin
          if (crm[n]) begin
            cr_next[CRF_W*n +: CRF_W] = c[CRF_W*n +: CRF_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_flag_commit.sv
// -----------------------------------------------------------------------------
// alu_flag_commit
// EX->WB stage directly downstream of the ALU. Registers the ALU result and
// flag vector, commits flags / mtxer / mtcrf data into the architectural XER
// and CR, drives GPR writeback, and feeds XER/CR back to the ALU.
//
// Configuration macro: ALU_FLAG_BYPASS_EN
//   defined   : XERrd/CRrd show the merged post-commit view of the WB slot;
//               flag_hazard is tied low.
//   undefined : XERrd/CRrd show the architectural registers; flag_hazard is
//               raised while the WB slot holds a pending XER/CR write.
//
// Ports (big-endian vectors):
//   clk, rst                    clock, synchronous active-high reset
//   ex_valid                    EX slot holds a real instruction
//   ex_C[0:31]                  ALU result; mtxer/mtcrf source data
//   ex_D[0:7]                   ALU flags {CA,OV,LT0,GT0,EQ0,LTx,GTx,EQx}
//   ex_rd[0:4], ex_gpr_we       GPR destination and write enable
//   ex_ca_we, ex_ov_we          XER flag update enables
//   ex_cr0_we, ex_crx_we        CR field 0 / compare field update enables
//   ex_crfd[0:2]                compare target field
//   ex_mtxer, ex_mtcrf          move-to XER / CR
//   ex_crm[0:7]                 mtcrf field mask
//   stall                       hold WB slot (beats flush)
//   flush                       kill the instruction in EX
//   wb_valid, wb_C, wb_rd       WB slot contents
//   wb_gpr_we                   GPR write strobe
//   XERrd, CRrd                 XER / CR view for the ALU and branch unit
//   flag_hazard                 EX must stall for a pending XER/CR write
// -----------------------------------------------------------------------------
module alu_flag_commit
  import alu_flag_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [0:ARCH_W-1] ex_C,
  input  logic [0:D_W-1]    ex_D,
  input  logic [0:RD_W-1]   ex_rd,
  input  logic              ex_gpr_we,
  input  logic              ex_ca_we,
  input  logic              ex_ov_we,
  input  logic              ex_cr0_we,
  input  logic              ex_crx_we,
  input  logic [0:CRFD_W-1] ex_crfd,
  input  logic              ex_mtxer,
  input  logic              ex_mtcrf,
  input  logic [0:CRF_N-1]  ex_crm,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic [0:ARCH_W-1] wb_C,
  output logic [0:RD_W-1]   wb_rd,
  output logic              wb_gpr_we,
  output logic [0:ARCH_W-1] XERrd,
  output logic [0:ARCH_W-1] CRrd,
  output logic              flag_hazard
);

  wb_slot_t          ex_slot;
  wb_slot_t          wb_q;
  logic [0:ARCH_W-1] xer_q;
  logic [0:ARCH_W-1] cr_q;
  logic [0:ARCH_W-1] xer_next;
  logic [0:ARCH_W-1] cr_next;

  assign ex_slot = '{
    valid:  ex_valid,
    c:      ex_C,
    d:      ex_D,
    rd:     ex_rd,
    gpr_we: ex_gpr_we,
    ca_we:  ex_ca_we,
    ov_we:  ex_ov_we,
    cr0_we: ex_cr0_we,
    crx_we: ex_crx_we,
    crfd:   ex_crfd,
    mtxer:  ex_mtxer,
    mtcrf:  ex_mtcrf,
    crm:    ex_crm
  };

  // Post-commit view of the current WB slot; a pass-through when the slot
  // is empty, so it can drive the arch registers unconditionally.
  alu_flag_commit_flag_merge u_flag_merge (
    .valid    (wb_q.valid),
    .d        (wb_q.d),
    .ca_we    (wb_q.ca_we),
    .ov_we    (wb_q.ov_we),
    .cr0_we   (wb_q.cr0_we),
    .crx_we   (wb_q.crx_we),
    .crfd     (wb_q.crfd),
    .mtxer    (wb_q.mtxer),
    .mtcrf    (wb_q.mtcrf),
    .crm      (wb_q.crm),
    .c        (wb_q.c),
    .xer      (xer_q),
    .cr       (cr_q),
    .xer_next (xer_next),
    .cr_next  (cr_next)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole slot, data fields included, is reset because wb_C and
      // wb_rd are visible outputs with a defined reset value; a pure datapath
      // register that is never observed before being written need not be.
      wb_q  <= '0;
      xer_q <= '0;
      cr_q  <= '0;
    end else if (!stall) begin
      // The slot commits on the edge it leaves WB. A stalled slot stays put
      // and does not commit, so each instruction commits exactly once.
      xer_q <= xer_next;
      cr_q  <= cr_next;
      if (flush) begin
        wb_q.valid <= 1'b0;
      end else begin
        wb_q <= ex_slot;
      end
    end
  end

  assign wb_valid  = wb_q.valid;
  assign wb_C      = wb_q.c;
  assign wb_rd     = wb_q.rd;
  assign wb_gpr_we = wb_q.valid & wb_q.gpr_we;

`ifdef ALU_FLAG_BYPASS_EN
  // The ALU sees flags as if the WB slot had already committed, so a
  // dependent instruction can issue back-to-back.
  assign XERrd       = xer_next;
  assign CRrd        = cr_next;
  assign flag_hazard = 1'b0;
`else
  // The ALU sees only committed state; EX must wait one cycle behind a
  // slot that still has an XER/CR write outstanding.
  assign XERrd       = xer_q;
  assign CRrd        = cr_q;
  assign flag_hazard = slot_writes_flags(wb_q);
`endif

endmodule

// File: tb/tb_alu_flag_commit.sv
// -----------------------------------------------------------------------------
// tb_alu_flag_commit
// Self-checking bench for alu_flag_commit. Expected WB outputs and the
// XER/CR value after each instruction commits are pushed to a scoreboard
// queue when the instruction is driven and compared when it reaches WB.
// -----------------------------------------------------------------------------
module tb_alu_flag_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [0:31] ex_C;
  logic [0:7]  ex_D;
  logic [0:4]  ex_rd;
  logic        ex_gpr_we;
  logic        ex_ca_we;
  logic        ex_ov_we;
  logic        ex_cr0_we;
  logic        ex_crx_we;
  logic [0:2]  ex_crfd;
  logic        ex_mtxer;
  logic        ex_mtcrf;
  logic [0:7]  ex_crm;
  logic        stall;
  logic        flush;
  logic        wb_valid;
  logic [0:31] wb_C;
  logic [0:4]  wb_rd;
  logic        wb_gpr_we;
  logic [0:31] XERrd;
  logic [0:31] CRrd;
  logic        flag_hazard;

  alu_flag_commit dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_C        (ex_C),
    .ex_D        (ex_D),
    .ex_rd       (ex_rd),
    .ex_gpr_we   (ex_gpr_we),
    .ex_ca_we    (ex_ca_we),
    .ex_ov_we    (ex_ov_we),
    .ex_cr0_we   (ex_cr0_we),
    .ex_crx_we   (ex_crx_we),
    .ex_crfd     (ex_crfd),
    .ex_mtxer    (ex_mtxer),
    .ex_mtcrf    (ex_mtcrf),
    .ex_crm      (ex_crm),
    .stall       (stall),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_C        (wb_C),
    .wb_rd       (wb_rd),
    .wb_gpr_we   (wb_gpr_we),
    .XERrd       (XERrd),
    .CRrd        (CRrd),
    .flag_hazard (flag_hazard)
  );

  always #5 clk = ~clk;

  // One instruction plus the arch state expected once it has committed.
  typedef struct {
    logic [31:0] c;
    logic [7:0]  d;
    logic [4:0]  rd;
    logic        gpr_we;
    logic        ca_we;
    logic        ov_we;
    logic        cr0_we;
    logic        crx_we;
    logic [2:0]  crfd;
    logic        mtxer;
    logic        mtcrf;
    logic [7:0]  crm;
    logic [31:0] exp_xer;
    logic [31:0] exp_cr;
  } vec_t;

  typedef struct {
    logic [31:0] c;
    logic [4:0]  rd;
    logic        gpr_we;
    logic [31:0] xer;
    logic [31:0] cr;
    logic        hazard;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t pend;
  bit   pend_valid = 1'b0;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] c, input logic [7:0] d, input logic [4:0] rd,
                              input logic gpr_we, input logic ca_we, input logic ov_we,
                              input logic cr0_we, input logic crx_we, input logic [2:0] crfd,
                              input logic mtxer, input logic mtcrf, input logic [7:0] crm,
                              input logic [31:0] exp_xer, input logic [31:0] exp_cr);
    vec_t v;
    v.c = c; v.d = d; v.rd = rd; v.gpr_we = gpr_we;
    v.ca_we = ca_we; v.ov_we = ov_we; v.cr0_we = cr0_we; v.crx_we = crx_we;
    v.crfd = crfd; v.mtxer = mtxer; v.mtcrf = mtcrf; v.crm = crm;
    v.exp_xer = exp_xer; v.exp_cr = exp_cr;
    return v;
  endfunction

  task automatic drive_idle();
    ex_valid = 1'b0; ex_C = '0; ex_D = '0; ex_rd = '0; ex_gpr_we = 1'b0;
    ex_ca_we = 1'b0; ex_ov_we = 1'b0; ex_cr0_we = 1'b0; ex_crx_we = 1'b0;
    ex_crfd = '0; ex_mtxer = 1'b0; ex_mtcrf = 1'b0; ex_crm = '0;
  endtask

  // Drive an instruction into EX; when 'expect_wb' it is pushed to the
  // scoreboard, otherwise it is expected never to reach WB.
  task automatic drive_op(input vec_t v, input bit expect_wb);
    exp_t e;
    ex_valid = 1'b1; ex_C = v.c; ex_D = v.d; ex_rd = v.rd; ex_gpr_we = v.gpr_we;
    ex_ca_we = v.ca_we; ex_ov_we = v.ov_we; ex_cr0_we = v.cr0_we; ex_crx_we = v.crx_we;
    ex_crfd = v.crfd; ex_mtxer = v.mtxer; ex_mtcrf = v.mtcrf; ex_crm = v.crm;
    if (expect_wb) begin
      e.c = v.c; e.rd = v.rd; e.gpr_we = v.gpr_we; e.xer = v.exp_xer; e.cr = v.exp_cr;
`ifdef ALU_FLAG_BYPASS_EN
      e.hazard = 1'b0;
`else
      e.hazard = v.ca_we | v.ov_we | v.cr0_we | v.crx_we | v.mtxer | v.mtcrf;
`endif
      sb_q.push_back(e);
    end
  endtask

  // Advance one clock, then compare anything the DUT produced on that edge.
  task automatic step();
    logic was_valid, was_stall, was_rst;
    exp_t e;
    was_valid = wb_valid;
    was_stall = stall;
    was_rst   = rst;
    @(posedge clk);
    #1;
    if (was_rst === 1'b1) begin
      pend_valid = 1'b0;
    end else begin
      if (was_valid === 1'b1 && was_stall === 1'b0 && pend_valid) begin
`ifndef ALU_FLAG_BYPASS_EN
        check("xer_commit", XERrd, pend.xer);
        check("cr_commit", CRrd, pend.cr);
`endif
        pend_valid = 1'b0;
      end
      if (wb_valid === 1'b1 && was_stall === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_wb: got wb_C=%h, expected no WB instruction", wb_C);
        end else begin
          e = sb_q.pop_front();
          check("wb_C", wb_C, e.c);
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_gpr_we", 32'(wb_gpr_we), 32'(e.gpr_we));
          check("flag_hazard", 32'(flag_hazard), 32'(e.hazard));
`ifdef ALU_FLAG_BYPASS_EN
          check("xer_bypass", XERrd, e.xer);
          check("cr_bypass", CRrd, e.cr);
`endif
          pend = e;
          pend_valid = 1'b1;
        end
      end
    end
  endtask

  initial begin
    //           c             d      rd gpr ca ov c0 cx crfd mtx mtc crm    exp_xer       exp_cr
    vecs[0] = mk(32'h0000_0010, 8'h00, 3, 1, 0, 0, 0, 0, 0,   0,  0,  8'h00, 32'h0000_0000, 32'h0000_0000); // add
    vecs[1] = mk(32'h8000_0000, 8'hE0, 4, 1, 1, 1, 1, 0, 0,   0,  0,  8'h00, 32'hE000_0000, 32'h9000_0000); // addco.
    vecs[2] = mk(32'h0000_0001, 8'h10, 5, 1, 1, 1, 1, 0, 0,   0,  0,  8'h00, 32'h8000_0000, 32'h5000_0000); // OV=0, SO sticky
    vecs[3] = mk(32'h0000_0000, 8'h00, 0, 0, 0, 0, 0, 0, 0,   1,  0,  8'h00, 32'h0000_0000, 32'h5000_0000); // mtxer clears SO
    vecs[4] = mk(32'h0000_0000, 8'h02, 0, 0, 0, 0, 0, 1, 5,   0,  0,  8'h00, 32'h0000_0000, 32'h5000_0400); // cmp crf5
    vecs[5] = mk(32'h0000_0000, 8'h39, 6, 0, 0, 0, 1, 1, 0,   0,  0,  8'h00, 32'h0000_0000, 32'h2000_0400); // crx beats cr0
    vecs[6] = mk(32'hA000_0005, 8'h00, 0, 0, 0, 0, 0, 0, 0,   0,  1,  8'h81, 32'h0000_0000, 32'hA000_0405); // mtcrf 0x81
    vecs[7] = mk(32'h3000_0000, 8'h60, 7, 1, 0, 1, 1, 0, 0,   0,  1,  8'h80, 32'hC000_0000, 32'h3000_0405); // mtcrf beats cr0
    vecs[8] = mk(32'h2000_0000, 8'h40, 0, 0, 1, 1, 0, 0, 0,   1,  0,  8'h00, 32'h2000_0000, 32'h3000_0405); // mtxer beats ca/ov
    vecs[9] = mk(32'h0000_00FF, 8'h44, 9, 1, 0, 1, 0, 1, 7,   0,  0,  8'h00, 32'hE000_0000, 32'h3000_0409); // cmp crf7, SO set

    // Reset: two cycles with rst high.
    drive_idle();
    stall = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;
    step();
    step();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_C", wb_C, 32'h0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_gpr_we", 32'(wb_gpr_we), 32'd0);
    check("rst_xer", XERrd, 32'h0);
    check("rst_cr", CRrd, 32'h0);
    check("rst_hazard", 32'(flag_hazard), 32'd0);
    rst = 1'b0;
    step();
    check("idle_xer", XERrd, 32'h0);
    check("idle_cr", CRrd, 32'h0);
    check("idle_wb_valid", 32'(wb_valid), 32'd0);

    // Table: back-to-back instructions, arch state accumulates.
    for (int i = 0; i < 10; i++) begin
      drive_op(vecs[i], 1'b1);
      step();
    end
    drive_idle();
    step();
    step();
    check("table_end_xer", XERrd, 32'hE000_0000);
    check("table_end_cr", CRrd, 32'h3000_0409);

    // Stall three cycles over a CA=0 slot; flush during the stall must not
    // kill the held slot, and XER may only change on the release edge.
    drive_op(mk(32'h0000_0042, 8'h00, 2, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00,
                32'hC000_0000, 32'h3000_0409), 1'b1);
    step();
    drive_op(mk(32'hDEAD_BEEF, 8'h80, 1, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00,
                32'h0, 32'h0), 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_wb_valid", 32'(wb_valid), 32'd1);
      check("stall_wb_C", wb_C, 32'h0000_0042);
`ifdef ALU_FLAG_BYPASS_EN
      check("stall_xer", XERrd, 32'hC000_0000);
`else
      check("stall_xer", XERrd, 32'hE000_0000);
`endif
    end
    stall = 1'b0;
    flush = 1'b0;
    drive_idle();
    step();
    check("release_wb_valid", 32'(wb_valid), 32'd0);
    step();
    check("release_xer", XERrd, 32'hC000_0000);

    // Flushed EX instruction becomes a bubble; an invalid slot with flag
    // enables set leaves the arch state alone.
    drive_op(mk(32'h1111_1111, 8'hFF, 3, 1, 1, 1, 1, 0, 0, 0, 0, 8'h00,
                32'h0, 32'h0), 1'b0);
    flush = 1'b1;
    step();
    check("flush_bubble", 32'(wb_valid), 32'd0);
    flush = 1'b0;
    ex_valid = 1'b0;
    step();
    check("invalid_gpr_we", 32'(wb_gpr_we), 32'd0);
    check("invalid_hazard", 32'(flag_hazard), 32'd0);
    drive_idle();
    step();
    check("invalid_xer", XERrd, 32'hC000_0000);
    check("invalid_cr", CRrd, 32'h3000_0409);

    // Reset while a flag-writing slot is stalled: the slot is discarded.
    drive_op(mk(32'hFFFF_FFFF, 8'hFF, 31, 1, 1, 1, 1, 0, 0, 1, 1, 8'hFF,
                32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1);
    step();
    drive_idle();
    stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst   = 1'b0;
    stall = 1'b0;
    check("rst_stall_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_stall_xer", XERrd, 32'h0);
    check("rst_stall_cr", CRrd, 32'h0);
    step();
    check("rst_stall_xer_after", XERrd, 32'h0);
    check("rst_stall_cr_after", CRrd, 32'h0);

    // addc then adde back-to-back.
    drive_op(mk(32'h0000_1234, 8'h80, 4, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00,
                32'h2000_0000, 32'h0), 1'b1);
    step();
`ifdef ALU_FLAG_BYPASS_EN
    check("adde_hazard", 32'(flag_hazard), 32'd0);
    check("adde_ca_bypass", 32'(XERrd[2]), 32'd1);
`else
    check("addc_hazard_on", 32'(flag_hazard), 32'd1);
    check("addc_ca_not_yet", 32'(XERrd[2]), 32'd0);
    drive_idle();
    step();
    check("addc_hazard_off", 32'(flag_hazard), 32'd0);
    check("adde_ca_visible", 32'(XERrd[2]), 32'd1);
`endif
    drive_op(mk(32'h0000_1235, 8'h00, 5, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00,
                32'h0000_0000, 32'h0), 1'b1);
    step();
    drive_idle();
    step();
    step();
    check("adde_xer", XERrd, 32'h0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
